// File: rtl/ym2612_pkg.sv
// Shared constants, types and helpers for the YM2612 host-bus responder
// and its two interval timers.
package ym2612_pkg;

  localparam logic [7:0] ADDR_TIMER_A_HI = 8'h24;
  localparam logic [7:0] ADDR_TIMER_A_LO = 8'h25;
  localparam logic [7:0] ADDR_TIMER_B    = 8'h26;
  localparam logic [7:0] ADDR_TIMER_CTRL = 8'h27;

  localparam int CTRL_LOAD_A     = 0;
  localparam int CTRL_LOAD_B     = 1;
  localparam int CTRL_EN_A       = 2;
  localparam int CTRL_EN_B       = 3;
  localparam int CTRL_RST_FLAG_A = 4;
  localparam int CTRL_RST_FLAG_B = 5;

  localparam int STAT_BUSY   = 7;
  localparam int STAT_FLAG_B = 1;
  localparam int STAT_FLAG_A = 0;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_WRITE,
    BUS_READ,
    BUS_ILLEGAL
  } bus_phase_e;

  typedef struct packed {
    logic en_b;
    logic en_a;
    logic load_b;
    logic load_a;
  } timer_ctrl_t;

  // Simultaneous nRD and nWR low is treated as neither a read nor a write.
  function automatic bus_phase_e decode_phase(input logic ncs, input logic nwr, input logic nrd);
    bus_phase_e ph;
    ph = BUS_IDLE;
    if (!ncs) begin
      if (!nwr && !nrd)     ph = BUS_ILLEGAL;
      else if (!nwr)        ph = BUS_WRITE;
      else if (!nrd)        ph = BUS_READ;
    end
    return ph;
  endfunction

  function automatic logic [7:0] status_byte(input logic busy, input logic flag_b, input logic flag_a);
    logic [7:0] s;
    s              = '0;
    s[STAT_BUSY]   = busy;
    s[STAT_FLAG_B] = flag_b;
    s[STAT_FLAG_A] = flag_a;
    return s;
  endfunction

endpackage

// File: rtl/ym2612_bus_responder_if.sv
// Host-side strobes/address plus the chip's write-event and status outputs.
// DATA is bidirectional and stays a plain port on the responder.
interface ym2612_bus_responder_if;

  logic       nCS;
  logic       nWR;
  logic       nRD;
  logic       A0;
  logic       A1;

  logic       nIRQ;
  logic       wr_valid;
  logic       wr_port;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       drop_err;

  modport master (
    output nCS, nWR, nRD, A0, A1,
    input  nIRQ, wr_valid, wr_port, wr_addr, wr_data, busy, drop_err
  );

  modport slave (
    input  nCS, nWR, nRD, A0, A1,
    output nIRQ, wr_valid, wr_port, wr_addr, wr_data, busy, drop_err
  );

endinterface

// File: rtl/ym2612_timer.sv
// One YM2612 interval timer: an up-counter that reloads from its period
// register on overflow and raises a sticky flag when enabled.
module ym2612_timer #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         tick,
  input  logic         load,
  input  logic         enable,
  input  logic         flag_clr,
  input  logic [W-1:0] reload,
  output logic         flag
);

  logic [W-1:0] cnt;
  logic         load_q;
  logic         load_rise;
  logic         ovf;

  assign load_rise = load & ~load_q;
  assign ovf       = load & load_q & tick & (cnt == '1);

  // A fresh load takes priority over a coincident tick so the first period is whole.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      load_q <= 1'b0;
      flag   <= 1'b0;
    end else begin
      load_q <= load;
      if (load_rise)
        cnt <= reload;
      else if (load && tick)
        cnt <= (cnt == '1) ? reload : cnt + W'(1);
      if (flag_clr)
        flag <= 1'b0;
      else if (ovf && enable)
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/ym2612_bus_responder.sv
// Chip-side YM2612 bus endpoint: decodes address/data writes, answers status
// reads, runs Timer A/B and forwards accepted data writes downstream.
module ym2612_bus_responder
  import ym2612_pkg::*;
#(
  parameter int BUSY_CYCLES = 32,
  parameter int TICK_DIV    = 72
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 nIC,
  ym2612_bus_responder_if.slave bus,
  inout  wire  [7:0]           DATA
);

  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic             rst;
  bus_phase_e       phase;
  logic             wact;
  logic             wact_q;
  logic             wstart;
  logic             rd_act;
  logic [1:0][7:0]  addr_latch;
  logic [7:0]       sel_addr;
  logic [BW-1:0]    busy_cnt;
  logic             busy_i;
  logic             data_wr;
  logic             accept;
  logic             timer_wr;

  logic             wr_valid_q;
  logic             wr_port_q;
  logic [7:0]       wr_addr_q;
  logic [7:0]       wr_data_q;
  logic             drop_err_q;
  logic             nirq_q;

  logic [9:0]       na;
  logic [7:0]       nb;
  timer_ctrl_t      ctrl;
  logic             clr_a;
  logic             clr_b;
  logic [PW-1:0]    presc;
  logic             tick;
  logic [3:0]       sub_b;
  logic             tick_b;
  logic             flag_a;
  logic             flag_b;
  logic [7:0]       status;

  assign rst      = RST | ~nIC;
  assign phase    = decode_phase(bus.nCS, bus.nWR, bus.nRD);
  assign wact     = (phase == BUS_WRITE);
  assign wstart   = wact & ~wact_q;
  assign rd_act   = (phase == BUS_READ);
  assign sel_addr = addr_latch[bus.A1];
  assign busy_i   = (busy_cnt != '0);
  assign data_wr  = wstart & bus.A0;
  assign accept   = data_wr & ~busy_i;
  assign timer_wr = accept & ~bus.A1;
  assign clr_a    = timer_wr & (sel_addr == ADDR_TIMER_CTRL) & DATA[CTRL_RST_FLAG_A];
  assign clr_b    = timer_wr & (sel_addr == ADDR_TIMER_CTRL) & DATA[CTRL_RST_FLAG_B];

  // wact_q resets high so a strobe still low at reset release is not taken as a new write.
  always_ff @(posedge CLK) begin
    if (rst) begin
      wact_q     <= 1'b1;
      addr_latch <= '0;
      busy_cnt   <= '0;
      wr_valid_q <= 1'b0;
      wr_port_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wact_q     <= wact;
      wr_valid_q <= accept;
      if (wstart && !bus.A0)
        addr_latch[bus.A1] <= DATA;
      if (accept) begin
        wr_port_q <= bus.A1;
        wr_addr_q <= sel_addr;
        wr_data_q <= DATA;
        busy_cnt  <= BW'(BUSY_CYCLES);
      end else if (busy_i) begin
        busy_cnt  <= busy_cnt - BW'(1);
      end
      if (data_wr && busy_i)
        drop_err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      na   <= '0;
      nb   <= '0;
      ctrl <= '0;
    end else if (timer_wr) begin
      case (sel_addr)
        ADDR_TIMER_A_HI: na[9:2] <= DATA;
        ADDR_TIMER_A_LO: na[1:0] <= DATA[1:0];
        ADDR_TIMER_B:    nb      <= DATA;
        ADDR_TIMER_CTRL: begin
          ctrl.load_a <= DATA[CTRL_LOAD_A];
          ctrl.load_b <= DATA[CTRL_LOAD_B];
          ctrl.en_a   <= DATA[CTRL_EN_A];
          ctrl.en_b   <= DATA[CTRL_EN_B];
        end
        default: ;
      endcase
    end
  end

  assign tick   = (presc == PW'(TICK_DIV - 1));
  assign tick_b = tick & (sub_b == 4'hF);

  // Both prescalers run freely from reset; loads do not realign them.
  always_ff @(posedge CLK) begin
    if (rst) begin
      presc  <= '0;
      sub_b  <= '0;
      nirq_q <= 1'b1;
    end else begin
      presc  <= tick ? '0 : presc + PW'(1);
      if (tick)
        sub_b <= sub_b + 4'd1;
      nirq_q <= ~(flag_a | flag_b);
    end
  end

  ym2612_timer #(.W(10)) u_timer_a (
    .CLK      (CLK),
    .RST      (rst),
    .tick     (tick),
    .load     (ctrl.load_a),
    .enable   (ctrl.en_a),
    .flag_clr (clr_a),
    .reload   (na),
    .flag     (flag_a)
  );

  ym2612_timer #(.W(8)) u_timer_b (
    .CLK      (CLK),
    .RST      (rst),
    .tick     (tick_b),
    .load     (ctrl.load_b),
    .enable   (ctrl.en_b),
    .flag_clr (clr_b),
    .reload   (nb),
    .flag     (flag_b)
  );

  assign status = status_byte(busy_i, flag_b, flag_a);
  assign DATA   = rd_act ? status : 8'hzz;

  assign bus.nIRQ     = nirq_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_port  = wr_port_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_i;
  assign bus.drop_err = drop_err_q;

endmodule

// File: tb/tb_ym2612_bus_responder.sv
// Bench for ym2612_bus_responder: directed and random bus traffic compared
// each cycle against a timestamp/tick-count reference model.
module tb_ym2612_bus_responder;

  localparam int BUSY_CYCLES = 32;
  localparam int TICK_DIV    = 2;

  logic       CLK;
  logic       RST;
  logic       nIC;
  logic [7:0] drv;
  logic       drvEn;
  logic       checking;
  wire  [7:0] DATA;

  int nVectors;
  int nMiscompares;

  ym2612_bus_responder_if bus ();

  assign DATA = drvEn ? drv : 8'hzz;

  ym2612_bus_responder #(
    .BUSY_CYCLES (BUSY_CYCLES),
    .TICK_DIV    (TICK_DIV)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .nIC  (nIC),
    .bus  (bus),
    .DATA (DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference model state: cycle index since reset, time of last accepted write,
  // and ticks remaining until each timer overflows.
  int       k;
  int       accK;
  bit       wactPrev;
  bit [7:0] lat [2];
  int       na, nb;
  bit       ldA, ldB, enA, enB, ldAPrev, ldBPrev;
  int       remA, remB;
  bit       fa, fb;
  bit       expIrqN, expWv, expPort, expDrop;
  bit [7:0] expAddr, expData;

  function automatic bit modelBusy();
    return (k - accK >= 1) && (k - accK <= BUSY_CYCLES);
  endfunction

  always @(posedge CLK) begin : refModel
    bit wact, wstart, busyNow, tickA, tickB, ovfA, ovfB, clrA, clrB;
    if (RST || !nIC) begin
      k = 0; accK = -1000000; wactPrev = 1'b1;
      lat[0] = 8'h00; lat[1] = 8'h00; na = 0; nb = 0;
      ldA = 0; ldB = 0; enA = 0; enB = 0; ldAPrev = 0; ldBPrev = 0;
      remA = 0; remB = 0; fa = 0; fb = 0;
      expIrqN = 1; expWv = 0; expPort = 0; expDrop = 0; expAddr = 0; expData = 0;
    end else begin
      wact     = !bus.nCS && !bus.nWR && bus.nRD;
      wstart   = wact && !wactPrev;
      wactPrev = wact;
      busyNow  = modelBusy();
      expIrqN  = !(fa || fb);
      tickA    = (k % TICK_DIV) == TICK_DIV - 1;
      tickB    = (k % (16 * TICK_DIV)) == 16 * TICK_DIV - 1;
      ovfA = 0; ovfB = 0; clrA = 0; clrB = 0;
      if (ldA && !ldAPrev) remA = 1024 - na;
      else if (ldA && tickA) begin
        remA--;
        if (remA == 0) begin ovfA = 1; remA = 1024 - na; end
      end
      if (ldB && !ldBPrev) remB = 256 - nb;
      else if (ldB && tickB) begin
        remB--;
        if (remB == 0) begin ovfB = 1; remB = 256 - nb; end
      end
      ldAPrev = ldA;
      ldBPrev = ldB;
      expWv = 0;
      if (wstart && !bus.A0) lat[bus.A1] = drv;
      else if (wstart && bus.A0) begin
        if (busyNow) expDrop = 1;
        else begin
          expWv = 1; expPort = bus.A1; expAddr = lat[bus.A1]; expData = drv; accK = k;
          if (!bus.A1) begin
            case (lat[0])
              8'h24: na = (int'(drv) << 2) | (na & 3);
              8'h25: na = (na & 1020) | (int'(drv) & 3);
              8'h26: nb = int'(drv);
              8'h27: begin
                ldA = drv[0]; ldB = drv[1]; enA = drv[2]; enB = drv[3];
                clrA = drv[4]; clrB = drv[5];
              end
              default: ;
            endcase
          end
        end
      end
      if (clrA) fa = 0; else if (ovfA && enA) fa = 1;
      if (clrB) fb = 0; else if (ovfB && enB) fb = 1;
      k++;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, actual, expected);
    end
  endtask

  always @(negedge CLK) begin
    if (checking) begin
      checkOutput("wr_valid", 16'(bus.wr_valid), 16'(expWv));
      checkOutput("wr_port",  16'(bus.wr_port),  16'(expPort));
      checkOutput("wr_addr",  16'(bus.wr_addr),  16'(expAddr));
      checkOutput("wr_data",  16'(bus.wr_data),  16'(expData));
      checkOutput("busy",     16'(bus.busy),     16'(modelBusy()));
      checkOutput("drop_err", 16'(bus.drop_err), 16'(expDrop));
      checkOutput("nIRQ",     16'(bus.nIRQ),     16'(expIrqN));
      if (!bus.nCS && !bus.nRD && bus.nWR)
        checkOutput("status", 16'(DATA), 16'({modelBusy(), 5'b0, fb, fa}));
    end
  end

  task automatic applyStimulus(input bit ncs, input bit nwr, input bit nrd,
                               input bit a0, input bit a1, input bit [7:0] d);
    @(posedge CLK);
    #1;
    bus.nCS = ncs; bus.nWR = nwr; bus.nRD = nrd; bus.A0 = a0; bus.A1 = a1;
    drv   = d;
    drvEn = !ncs && !nwr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 1, 0, 0, 8'h00);
  endtask

  task automatic statusRead(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00);
  endtask

  task automatic busWrite(input bit a1, input bit a0, input bit [7:0] d, input int len);
    for (int i = 0; i < len; i++) applyStimulus(0, 0, 1, a0, a1, d);
    idle(1);
  endtask

  task automatic regWrite(input bit a1, input bit [7:0] addr, input bit [7:0] d);
    busWrite(a1, 0, addr, 1);
    busWrite(a1, 1, d, 1);
    statusRead(BUSY_CYCLES + 1);
  endtask

  task automatic pulseReset(input bit useNic);
    @(posedge CLK);
    #1;
    if (useNic) nIC = 1'b0; else RST = 1'b1;
    @(posedge CLK);
    #1;
    nIC = 1'b1; RST = 1'b0;
  endtask

  initial begin
    bit [7:0] pool [7];
    int r;
    pool = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h30, 8'h2B};
    nVectors = 0; nMiscompares = 0; checking = 1'b0;
    bus.nCS = 1; bus.nWR = 1; bus.nRD = 1; bus.A0 = 0; bus.A1 = 0;
    drv = 8'h00; drvEn = 1'b0; RST = 1'b1; nIC = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    checking = 1'b1;
    idle(2);

    $display("[TB] key-on style write and busy window");
    busWrite(0, 0, 8'h28, 1);
    busWrite(0, 1, 8'hF0, 1);
    statusRead(40);

    $display("[TB] write while busy, address write while busy");
    busWrite(0, 1, 8'h01, 1);
    statusRead(4);
    busWrite(0, 1, 8'h02, 1);
    busWrite(0, 0, 8'h2B, 1);
    statusRead(BUSY_CYCLES);
    busWrite(0, 1, 8'h03, 1);
    statusRead(BUSY_CYCLES + 1);

    $display("[TB] port II then port I");
    regWrite(1, 8'h30, 8'h11);
    busWrite(0, 1, 8'h22, 1);
    statusRead(BUSY_CYCLES + 1);

    $display("[TB] Timer A near overflow");
    regWrite(0, 8'h24, 8'hFF);
    regWrite(0, 8'h25, 8'h00);
    regWrite(0, 8'h27, 8'h05);
    regWrite(0, 8'h27, 8'h15);
    regWrite(0, 8'h27, 8'h10);

    $display("[TB] Timer B fastest period, then hold");
    regWrite(0, 8'h26, 8'hFF);
    regWrite(0, 8'h27, 8'h0A);
    statusRead(80);
    regWrite(0, 8'h27, 8'h08);
    regWrite(0, 8'h27, 8'h28);
    statusRead(40);

    $display("[TB] long strobe, reset while busy, strobe held across reset");
    busWrite(0, 1, 8'h5A, 10);
    statusRead(BUSY_CYCLES + 2);
    busWrite(0, 1, 8'h66, 1);
    statusRead(5);
    pulseReset(0);
    statusRead(3);
    applyStimulus(0, 0, 1, 1, 0, 8'h77);
    pulseReset(1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 8'h77);
    idle(1);
    busWrite(0, 1, 8'h78, 1);
    statusRead(BUSY_CYCLES + 2);

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)       idle(1);
      else if (r < 55)  statusRead($urandom_range(1, 4));
      else if (r < 60)  applyStimulus(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      else if (r < 75)  busWrite(1'($urandom_range(0, 3) == 0), 0, pool[$urandom_range(0, 6)], $urandom_range(1, 3));
      else if (r < 98)  busWrite(1'($urandom_range(0, 3) == 0), 1,
                                 ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF8, 8'hFF)) : 8'($urandom),
                                 $urandom_range(1, 3));
      else              pulseReset(1'($urandom_range(0, 1)));
    end
    idle(4);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
